mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Shares one external memory bus between the core's instruction-fetch port (if_*) and its load/store port (ls_*).
- Handles one transaction at a time: arbitrate, bus request, bus grant, response.
- Data port has fixed priority, with a starvation guard for fetch.
- Fetch responses are squashed on pipeline flush (jump).
- A watchdog timeout returns an error pulse to the owning port.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- STARVE_LIMIT, 4, consecutive contested ls wins before fetch is forced to win.
- TIMEOUT, 255, max cycles from bus_req assertion to bus_rvalid; range 1..65535.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  pipeline flush; squashes the current/selected fetch.
- if_req  in  1  fetch request; held with if_addr stable until if_gnt.
- if_addr  in  ADDR_W  fetch address.
- if_gnt  out  1  fetch accepted by bus (1-cycle pulse).
- if_rvalid  out  1  fetch data valid (1-cycle pulse).
- if_rdata  out  DATA_W  fetch data; equals bus_rdata.
- if_err  out  1  fetch timeout (1-cycle pulse).
- ls_req  in  1  load/store request; fields held stable until ls_gnt.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  address.
- ls_wdata  in  DATA_W  store data.
- ls_be  in  DATA_W/8  byte enables.
- ls_gnt, ls_rvalid, ls_err  out  1  as the if_* equivalents; ls_rvalid also acknowledges stores.
- ls_rdata  out  DATA_W  load data; equals bus_rdata.
- bus_req  out  1  registered request.
- bus_we  out  1  registered.
- bus_addr  out  ADDR_W  registered.
- bus_wdata  out  DATA_W  registered.
- bus_be  out  DATA_W/8  registered; all-ones for fetch.
- bus_gnt  in  1  bus accepts the request in the cycle bus_req & bus_gnt.
- bus_rvalid  in  1  response valid.
- bus_rdata  in  DATA_W  response data.

Behaviour:
- Reset: all outputs 0, state=IDLE, owner=LS, discard=0, starve_cnt=0, wd_cnt=0. Applied asynchronously; a transaction in progress is abandoned, with no pulses afterward.
- FSM states: IDLE, REQ, RESP.
- IDLE → REQ:
  - Taken on any req.
  - Owner is LS if ls_req, except IF wins when if_req is set and starve_cnt==STARVE_LIMIT.
  - The owner's fields are latched into the bus_* registers and bus_req=1 from the next cycle. Fetch uses we=0 and be=all-ones.
- REQ:
  - bus_req and bus_* are held stable until bus_gnt.
  - On bus_req & bus_gnt: owner gnt pulses in that same cycle (combinational), bus_req drops next cycle, go RESP.
  - bus_rvalid is ignored in REQ.
- RESP:
  - On bus_rvalid: owner rvalid pulses in the same cycle (combinational from bus_rvalid), then go IDLE.
  - New arbitration happens in the following cycle, so there is a 1-cycle gap.
- rdata: if_rdata/ls_rdata = bus_rdata at all times; meaningful only with rvalid.
- Minimum latency: req sampled at edge 0; bus_req in cycle 1; gnt in cycle 1; rvalid earliest in cycle 2.
- Starvation counter:
  - starve_cnt += 1 (saturating at STARVE_LIMIT) when LS wins while if_req=1.
  - Cleared when IF wins.
  - Unchanged when LS wins uncontested.
- Flush:
  - flush=1 while owner=IF in REQ or RESP, or in IDLE in the cycle IF is selected, sets discard.
  - The bus handshake still completes; a bus request is never retracted.
  - With discard set, if_gnt, if_rvalid and if_err are suppressed.
  - discard clears on return to IDLE.
  - flush has no effect on LS transactions.
- Watchdog:
  - wd_cnt clears on entering REQ and increments each cycle in REQ/RESP.
  - When wd_cnt==TIMEOUT without completion: owner err pulses 1 cycle, bus_req→0, go IDLE; a late bus_rvalid is ignored.
  - Completion in the same cycle as the timeout wins: rvalid is given, err is not.
- Same-cycle arrival: simultaneous if_req and ls_req with starve_cnt<STARVE_LIMIT → LS owner.
- One-hot outputs: at most one of gnt/rvalid/err per port per cycle, and never both ports in the same cycle.

Test Plan:
- LS load, addr 0x100, bus_gnt in the 1st REQ cycle, bus_rvalid 2 cycles later with 0xDEADBEEF → ls_gnt at cycle 1; ls_rvalid with ls_rdata=0xDEADBEEF at cycle 3; IF outputs stay 0.
- if_req and ls_req continuously asserted, STARVE_LIMIT=4 → grant order LS,LS,LS,LS,IF,LS,LS,LS,LS,IF.
- IF fetch at 0x80000000, flush pulsed 1 cycle after bus_gnt → bus transaction completes; if_rvalid never asserted; next arbitration normal.
- Store with be=4'b0011, wdata=0x1234 → bus_we=1, bus_be=0011, bus_wdata=0x1234 held stable across 3 cycles of bus_gnt=0; ls_rvalid on ack.
- TIMEOUT=8, bus_gnt never asserted → ls_err pulse exactly 8 cycles after bus_req rises; bus_req low after; a stray bus_rvalid is ignored.
- rst asserted asynchronously mid-RESP → all outputs 0 immediately; after release, state IDLE and starve_cnt=0.

Source files
------------

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one external memory bus between the instruction-fetch port (if_*)
// and the load/store port (ls_*). One transaction is in flight at a time:
// arbitrate in IDLE, present a registered request in REQ until the bus grants
// it, then wait in RESP for the response. The data port wins by default, but a
// starvation counter forces a fetch win after STARVE_LIMIT consecutive
// contested data wins. A pipeline flush squashes the fetch currently owning
// the bus. A watchdog returns an error pulse if a transaction takes too long.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   flush               squashes the current / just-selected fetch
//   if_req, if_addr     fetch request (held until if_gnt)
//   if_gnt/rvalid/err   fetch handshake pulses, if_rdata = bus_rdata
//   ls_req, ls_we, ls_addr, ls_wdata, ls_be
//                       load/store request (held until ls_gnt)
//   ls_gnt/rvalid/err   load/store handshake pulses, ls_rdata = bus_rdata
//   bus_req/we/addr/wdata/be
//                       registered request to the memory bus
//   bus_gnt, bus_rvalid, bus_rdata
//                       memory bus acceptance and response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,

    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_err,

    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                ls_err,

    output logic                bus_req,
    output logic                bus_we,
    output logic [ADDR_W-1:0]   bus_addr,
    output logic [DATA_W-1:0]   bus_wdata,
    output logic [DATA_W/8-1:0] bus_be,
    input  logic                bus_gnt,
    input  logic                bus_rvalid,
    input  logic [DATA_W-1:0]   bus_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int SC_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);
    localparam logic [15:0]     WD_MAX     = 16'(TIMEOUT);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic OWN_LS = 1'b0;
    localparam logic OWN_IF = 1'b1;

    logic [1:0]        state_q,      state_d;
    logic              owner_q,      owner_d;
    logic              discard_q,    discard_d;
    logic [SC_W-1:0]   starve_cnt_q, starve_cnt_d;
    logic [15:0]       wd_cnt_q,     wd_cnt_d;
    logic              bus_req_q,    bus_req_d;
    logic              bus_we_q,     bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q,  bus_wdata_d;
    logic [BE_W-1:0]   bus_be_q,     bus_be_d;

    logic busy;
    logic timeout;
    logic handshake;
    logic response;
    logic if_squash;
    logic sel_if;

    assign busy = (state_q == ST_REQ) || (state_q == ST_RESP);

    // A response arriving in the same cycle the watchdog expires completes the
    // transaction normally. In REQ the watchdog wins over a late grant so that
    // gnt and err never pulse together.
    assign timeout   = busy && (wd_cnt_q == WD_MAX) && !((state_q == ST_RESP) && bus_rvalid);
    assign handshake = (state_q == ST_REQ) && bus_req_q && bus_gnt && !timeout;
    assign response  = (state_q == ST_RESP) && bus_rvalid;

    // A flush in the current cycle squashes the fetch immediately; discard_q
    // remembers it for the rest of the transaction.
    assign if_squash = discard_q || flush;

    // Data port wins unless fetch has been starved long enough.
    assign sel_if = if_req && (!ls_req || (starve_cnt_q == STARVE_MAX));

    assign if_gnt    = handshake && (owner_q == OWN_IF) && !if_squash;
    assign if_rvalid = response  && (owner_q == OWN_IF) && !if_squash;
    assign if_err    = timeout   && (owner_q == OWN_IF) && !if_squash;
    assign ls_gnt    = handshake && (owner_q == OWN_LS);
    assign ls_rvalid = response  && (owner_q == OWN_LS);
    assign ls_err    = timeout   && (owner_q == OWN_LS);

    assign if_rdata  = bus_rdata;
    assign ls_rdata  = bus_rdata;

    assign bus_req   = bus_req_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;
    assign bus_be    = bus_be_q;

    always_comb begin
        // NOTE: every signal driven here gets a hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d      = state_q;
        owner_d      = owner_q;
        discard_d    = discard_q;
        starve_cnt_d = starve_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        bus_req_d    = bus_req_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_be_d     = bus_be_q;

        case (state_q)
            ST_IDLE: begin
                if (if_req || ls_req) begin
                    state_d   = ST_REQ;
                    bus_req_d = 1'b1;
                    wd_cnt_d  = '0;
                    if (sel_if) begin
                        owner_d      = OWN_IF;
                        discard_d    = flush;
                        starve_cnt_d = '0;
                        bus_we_d     = 1'b0;
                        bus_addr_d   = if_addr;
                        bus_wdata_d  = '0;
                        bus_be_d     = '1;
                    end else begin
                        owner_d     = OWN_LS;
                        discard_d   = 1'b0;
                        bus_we_d    = ls_we;
                        bus_addr_d  = ls_addr;
                        bus_wdata_d = ls_wdata;
                        bus_be_d    = ls_be;
                        // Only a contested data win counts towards starvation.
                        if (if_req && (starve_cnt_q != STARVE_MAX)) begin
                            starve_cnt_d = starve_cnt_q + 1'b1;
                        end
                    end
                end
            end

            ST_REQ: begin
                wd_cnt_d = wd_cnt_q + 16'd1;
                if ((owner_q == OWN_IF) && flush) begin
                    discard_d = 1'b1;
                end
                if (timeout) begin
                    state_d   = ST_IDLE;
                    bus_req_d = 1'b0;
                    discard_d = 1'b0;
                end else if (bus_gnt) begin
                    state_d   = ST_RESP;
                    bus_req_d = 1'b0;
                end
            end

            ST_RESP: begin
                wd_cnt_d = wd_cnt_q + 16'd1;
                if ((owner_q == OWN_IF) && flush) begin
                    discard_d = 1'b1;
                end
                if (response || timeout) begin
                    state_d   = ST_IDLE;
                    discard_d = 1'b0;
                end
            end

            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
                discard_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_LS;
            discard_q    <= 1'b0;
            starve_cnt_q <= '0;
            wd_cnt_q     <= '0;
            bus_req_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_be_q     <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // computed from the pre-edge state, independent of statement order.
            state_q      <= state_d;
            owner_q      <= owner_d;
            discard_q    <= discard_d;
            starve_cnt_q <= starve_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            bus_req_q    <= bus_req_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_be_q     <= bus_be_d;
        end
    end

endmodule
